// File: rtl/gpio_in_event_detect.sv
// Always-on GPIO input path: per-pin synchroniser, prescaled debounce and edge/level
// event detection. Produces sticky status, a level interrupt and a one-cycle wake pulse.
module gpio_in_event_detect #(
    parameter int NB_GPIO    = 32,
    parameter int PRESC_W    = 8,
    parameter int DEBOUNCE_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_GPIO-1:0]    gpio_in_i,
    input  logic [PRESC_W-1:0]    presc_i,
    input  logic [DEBOUNCE_W-1:0] debounce_i,
    input  logic [NB_GPIO-1:0]    en_i,
    input  logic [2*NB_GPIO-1:0]  type_i,
    input  logic [NB_GPIO-1:0]    clr_i,
    output logic [NB_GPIO-1:0]    gpio_sync_o,
    output logic [NB_GPIO-1:0]    status_o,
    output logic                  irq_o,
    output logic                  wake_o
);

    logic [NB_GPIO-1:0]    s1;
    logic [NB_GPIO-1:0]    s2;
    logic [NB_GPIO-1:0]    deb;
    logic [NB_GPIO-1:0]    deb_nxt;
    logic [NB_GPIO-1:0]    prev;
    logic [PRESC_W-1:0]    presc_cnt;
    logic                  tick;
    logic [DEBOUNCE_W-1:0] cnt     [NB_GPIO];
    logic [DEBOUNCE_W-1:0] cnt_nxt [NB_GPIO];
    logic [NB_GPIO-1:0]    rise;
    logic [NB_GPIO-1:0]    fall;
    logic [NB_GPIO-1:0]    evt;
    logic [NB_GPIO-1:0]    status;
    logic                  irq;
    logic                  wake;

    // A count above a freshly lowered compare value wraps silently, without a tick.
    assign tick = (presc_cnt == presc_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_cnt <= '0;
        end else if (presc_cnt >= presc_i) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gpio_in_i;
            s2 <= s1;
        end
    end

    // debounce_i == 0 follows the synchronised value directly; otherwise the pin
    // must disagree with deb for debounce_i consecutive ticks.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < NB_GPIO; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s2[i] == deb[i]) begin
                cnt_nxt[i] = '0;
            end else if (debounce_i == '0) begin
                deb_nxt[i] = s2[i];
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (({1'b0, cnt[i]} + (DEBOUNCE_W+1)'(1)) >= {1'b0, debounce_i}) begin
                    deb_nxt[i] = s2[i];
                    cnt_nxt[i] = '0;
                end else if (cnt[i] != '1) begin
                    cnt_nxt[i] = cnt[i] + DEBOUNCE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb  <= '0;
            prev <= '0;
            for (int i = 0; i < NB_GPIO; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb  <= deb_nxt;
            prev <= deb;
            for (int i = 0; i < NB_GPIO; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign rise = deb & ~prev;
    assign fall = ~deb & prev;

    always_comb begin
        evt = '0;
        for (int i = 0; i < NB_GPIO; i++) begin
            case (type_i[2*i +: 2])
                2'b00:   evt[i] = en_i[i] & rise[i];
                2'b01:   evt[i] = en_i[i] & fall[i];
                2'b10:   evt[i] = en_i[i] & (rise[i] | fall[i]);
                default: evt[i] = en_i[i] & deb[i];
            endcase
        end
    end

    // A new event outranks a clear in the same cycle, so level events re-assert.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status <= '0;
            irq    <= 1'b0;
            wake   <= 1'b0;
        end else begin
            status <= evt | (status & ~clr_i);
            irq    <= |status;
            wake   <= |(evt & ~status);
        end
    end

    assign gpio_sync_o = deb;
    assign status_o    = status;
    assign irq_o       = irq;
    assign wake_o      = wake;

endmodule

// File: tb/tb_gpio_in_event_detect.sv
// Directed bench for gpio_in_event_detect: latency, debounce glitch filtering,
// level-type clear behaviour, multi-pin wake and asynchronous reset.
module tb_gpio_in_event_detect;

    localparam int NB = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NB-1:0] gpio_in_i;
    logic [7:0]    presc_i;
    logic [3:0]    debounce_i;
    logic [NB-1:0] en_i;
    logic [2*NB-1:0] type_i;
    logic [NB-1:0] clr_i;
    logic [NB-1:0] gpio_sync_o;
    logic [NB-1:0] status_o;
    logic          irq_o;
    logic          wake_o;

    int errors = 0;
    int checks = 0;

    gpio_in_event_detect #(.NB_GPIO(NB), .PRESC_W(8), .DEBOUNCE_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .gpio_in_i   (gpio_in_i),
        .presc_i     (presc_i),
        .debounce_i  (debounce_i),
        .en_i        (en_i),
        .type_i      (type_i),
        .clr_i       (clr_i),
        .gpio_sync_o (gpio_sync_o),
        .status_o    (status_o),
        .irq_o       (irq_o),
        .wake_o      (wake_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        gpio_in_i = '0;
        clr_i     = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_i = 1'b1; gpio_in_i = '0; presc_i = '0; debounce_i = '0;
        en_i = '0; type_i = '0; clr_i = '0;

        // 1: bypass debounce, rise on pin 3, latency and clear
        en_i = 32'h8; type_i = '0;
        do_reset();
        check("rst_status", status_o, 32'h0);
        check("rst_sync", gpio_sync_o, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        check("rst_wake", {31'b0, wake_o}, 32'h0);
        gpio_in_i = 32'h8;
        step(3);
        check("t1_sync_e3", gpio_sync_o, 32'h8);
        check("t1_status_e3", status_o, 32'h0);
        step(1);
        check("t1_status_e4", status_o, 32'h8);
        check("t1_wake_e4", {31'b0, wake_o}, 32'h1);
        check("t1_irq_e4", {31'b0, irq_o}, 32'h0);
        step(1);
        check("t1_wake_e5", {31'b0, wake_o}, 32'h0);
        check("t1_irq_e5", {31'b0, irq_o}, 32'h1);
        clr_i = 32'h8;
        step(1);
        clr_i = '0;
        check("t1_status_clr", status_o, 32'h0);
        check("t1_irq_clr0", {31'b0, irq_o}, 32'h1);
        step(1);
        check("t1_irq_clr1", {31'b0, irq_o}, 32'h0);

        // 2: tick every 4 cycles, 2 stable ticks; ticks land on edges 4,8,12,...
        presc_i = 8'd3; debounce_i = 4'd2; en_i = 32'h1; type_i = 64'h2;
        do_reset();
        step(2);
        gpio_in_i = 32'h1;
        step(6);
        gpio_in_i = 32'h0;
        step(3);
        check("t2_glitch", gpio_sync_o, 32'h0);
        step(1);
        gpio_in_i = 32'h1;
        step(7);
        check("t2_one_tick", gpio_sync_o, 32'h0);
        step(1);
        check("t2_two_ticks", gpio_sync_o, 32'h1);
        check("t2_status_pre", status_o, 32'h0);
        step(1);
        check("t2_status", status_o, 32'h1);
        check("t2_wake", {31'b0, wake_o}, 32'h1);

        // 3: level-high on pin 5 survives clear while held high
        presc_i = '0; debounce_i = '0; en_i = 32'h20; type_i = 64'hC00;
        do_reset();
        gpio_in_i = 32'h20;
        step(4);
        check("t3_status", status_o, 32'h20);
        check("t3_wake", {31'b0, wake_o}, 32'h1);
        step(1);
        check("t3_wake_once", {31'b0, wake_o}, 32'h0);
        clr_i = 32'h20;
        step(1);
        clr_i = '0;
        check("t3_clr_held", status_o, 32'h20);
        check("t3_clr_nowake", {31'b0, wake_o}, 32'h0);
        step(1);
        check("t3_nowake2", {31'b0, wake_o}, 32'h0);
        gpio_in_i = 32'h0;
        step(4);
        check("t3_low_sticky", status_o, 32'h20);
        clr_i = 32'h20;
        step(1);
        clr_i = '0;
        check("t3_clr_low", status_o, 32'h0);
        step(1);
        check("t3_irq_low", {31'b0, irq_o}, 32'h0);

        // 4: two pins rise together, falls ignored, disabled pins ignored
        en_i = 32'h6; type_i = '0;
        do_reset();
        gpio_in_i = 32'h6;
        step(4);
        check("t4_status", status_o, 32'h6);
        check("t4_wake", {31'b0, wake_o}, 32'h1);
        step(1);
        check("t4_wake_single", {31'b0, wake_o}, 32'h0);
        gpio_in_i = 32'h0;
        step(5);
        check("t4_fall_status", status_o, 32'h6);
        check("t4_fall_wake", {31'b0, wake_o}, 32'h0);
        clr_i = 32'h6;
        step(1);
        clr_i = '0;
        check("t4_clr", status_o, 32'h0);
        en_i = '0;
        gpio_in_i = 32'h6;
        step(5);
        check("t4_dis_status", status_o, 32'h0);
        check("t4_dis_sync", gpio_sync_o, 32'h6);

        // 5: async reset during a debounce run with all low pins set
        en_i = 32'hFF; type_i = '0;
        do_reset();
        gpio_in_i = 32'hFF;
        step(4);
        check("t5_status", status_o, 32'hFF);
        step(1);
        check("t5_irq", {31'b0, irq_o}, 32'h1);
        debounce_i = 4'd3;
        gpio_in_i = 32'h1FF;
        step(4);
        #2;
        rst_i = 1'b1;
        #1;
        check("t5_async_status", status_o, 32'h0);
        check("t5_async_sync", gpio_sync_o, 32'h0);
        check("t5_async_irq", {31'b0, irq_o}, 32'h0);
        check("t5_async_wake", {31'b0, wake_o}, 32'h0);
        debounce_i = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(3);
        check("t5_rel_sync", gpio_sync_o, 32'h1FF);
        check("t5_rel_status_e3", status_o, 32'h0);
        step(1);
        check("t5_rel_status", status_o, 32'hFF);
        check("t5_rel_wake", {31'b0, wake_o}, 32'h1);
        step(1);
        check("t5_rel_wake_off", {31'b0, wake_o}, 32'h0);
        check("t5_rel_irq", {31'b0, irq_o}, 32'h1);
        step(3);
        check("t5_rel_once", {31'b0, wake_o}, 32'h0);
        check("t5_rel_hold", status_o, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
